// File: rtl/coproc_sequencer.sv
// coproc_sequencer: frame sequencer for the stream matrix-multiply coprocessor.
// Ports: S_AXIS_* in, M_AXIS_* out, A/B RAM write, MM_Start/Done, RES RAM read, frame_err.
module coproc_sequencer #(
    parameter int width          = 8,
    parameter int A_depth_bits   = 3,
    parameter int B_depth_bits   = 2,
    parameter int RES_depth_bits = 1,
    parameter int AXIS_width     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [AXIS_width-1:0]     S_AXIS_TDATA,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,
    input  logic                      S_AXIS_TLAST,
    output logic [AXIS_width-1:0]     M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic                      M_AXIS_TLAST,
    output logic                      A_write_en,
    output logic [A_depth_bits-1:0]   A_write_address,
    output logic [width-1:0]          A_write_data_in,
    output logic                      B_write_en,
    output logic [B_depth_bits-1:0]   B_write_address,
    output logic [width-1:0]          B_write_data_in,
    output logic                      MM_Start,
    input  logic                      MM_Done,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out,
    output logic                      frame_err
);

    localparam int A_ELEMS   = 2 ** A_depth_bits;
    localparam int B_ELEMS   = 2 ** B_depth_bits;
    localparam int RES_ELEMS = 2 ** RES_depth_bits;
    localparam int N_BEATS   = A_ELEMS + B_ELEMS;
    localparam int CNT_W     = $clog2(N_BEATS + 1);

    localparam logic [CNT_W-1:0] A_N    = CNT_W'(A_ELEMS);
    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(N_BEATS - 1);
    localparam logic [CNT_W-1:0] ONE_N  = CNT_W'(1);
    localparam logic [RES_depth_bits-1:0] LAST_R = RES_depth_bits'(RES_ELEMS - 1);
    localparam logic [RES_depth_bits-1:0] ONE_R  = RES_depth_bits'(1);

    // Write_Outputs is split into issue / latency / present phases.
    typedef enum logic [2:0] {
        IDLE,
        READ_INPUTS,
        COMPUTE,
        RD_ISSUE,
        RD_WAIT,
        PRESENT
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]          n, n_nx, b_off;
    logic [RES_depth_bits-1:0] r, r_nx;

    logic                      tready_nx;
    logic [AXIS_width-1:0]     tdata_nx;
    logic                      tvalid_nx, tlast_nx;
    logic                      a_we_nx, b_we_nx;
    logic [A_depth_bits-1:0]   a_addr_nx;
    logic [B_depth_bits-1:0]   b_addr_nx;
    logic [width-1:0]          a_data_nx, b_data_nx;
    logic                      start_nx, rd_en_nx, ferr_nx;
    logic [RES_depth_bits-1:0] rd_addr_nx;

    logic beat, last_beat;

    // Only the low word bits are stored; the rest of TDATA is ignored.
    logic unused_tdata;
    assign unused_tdata = ^S_AXIS_TDATA;

    assign beat      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign last_beat = (n == LAST_N);
    assign b_off     = n - A_N;

    always_comb begin
        state_nx   = state;
        n_nx       = n;
        r_nx       = r;
        tready_nx  = S_AXIS_TREADY;
        tdata_nx   = M_AXIS_TDATA;
        tvalid_nx  = M_AXIS_TVALID;
        tlast_nx   = M_AXIS_TLAST;
        a_we_nx    = 1'b0;
        a_addr_nx  = A_write_address;
        a_data_nx  = A_write_data_in;
        b_we_nx    = 1'b0;
        b_addr_nx  = B_write_address;
        b_data_nx  = B_write_data_in;
        start_nx   = 1'b0;
        rd_en_nx   = 1'b0;
        rd_addr_nx = RES_read_address;
        ferr_nx    = frame_err;

        unique case (state)
            IDLE: begin
                n_nx      = '0;
                r_nx      = '0;
                tready_nx = 1'b1;
                state_nx  = READ_INPUTS;
            end
            READ_INPUTS: begin
                if (beat) begin
                    if (n < A_N) begin
                        a_we_nx   = 1'b1;
                        a_addr_nx = n[A_depth_bits-1:0];
                        a_data_nx = S_AXIS_TDATA[width-1:0];
                    end else begin
                        b_we_nx   = 1'b1;
                        b_addr_nx = b_off[B_depth_bits-1:0];
                        b_data_nx = S_AXIS_TDATA[width-1:0];
                    end
                    // The beat count delimits the frame; TLAST only flags.
                    if (S_AXIS_TLAST != last_beat) begin
                        ferr_nx = 1'b1;
                    end
                    if (last_beat) begin
                        tready_nx = 1'b0;
                        start_nx  = 1'b1;
                        n_nx      = '0;
                        state_nx  = COMPUTE;
                    end else begin
                        n_nx = n + ONE_N;
                    end
                end
            end
            COMPUTE: begin
                if (MM_Done) begin
                    rd_en_nx   = 1'b1;
                    rd_addr_nx = r;
                    state_nx   = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                tdata_nx  = AXIS_width'(RES_read_data_out);
                tvalid_nx = 1'b1;
                tlast_nx  = (r == LAST_R);
                state_nx  = PRESENT;
            end
            PRESENT: begin
                if (M_AXIS_TREADY) begin
                    tvalid_nx = 1'b0;
                    tlast_nx  = 1'b0;
                    if (r == LAST_R) begin
                        state_nx = IDLE;
                    end else begin
                        r_nx       = r + ONE_R;
                        rd_en_nx   = 1'b1;
                        rd_addr_nx = r + ONE_R;
                        state_nx   = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            n                <= '0;
            r                <= '0;
            S_AXIS_TREADY    <= 1'b0;
            M_AXIS_TDATA     <= '0;
            M_AXIS_TVALID    <= 1'b0;
            M_AXIS_TLAST     <= 1'b0;
            A_write_en       <= 1'b0;
            A_write_address  <= '0;
            A_write_data_in  <= '0;
            B_write_en       <= 1'b0;
            B_write_address  <= '0;
            B_write_data_in  <= '0;
            MM_Start         <= 1'b0;
            RES_read_en      <= 1'b0;
            RES_read_address <= '0;
            frame_err        <= 1'b0;
        end else begin
            state            <= state_nx;
            n                <= n_nx;
            r                <= r_nx;
            S_AXIS_TREADY    <= tready_nx;
            M_AXIS_TDATA     <= tdata_nx;
            M_AXIS_TVALID    <= tvalid_nx;
            M_AXIS_TLAST     <= tlast_nx;
            A_write_en       <= a_we_nx;
            A_write_address  <= a_addr_nx;
            A_write_data_in  <= a_data_nx;
            B_write_en       <= b_we_nx;
            B_write_address  <= b_addr_nx;
            B_write_data_in  <= b_data_nx;
            MM_Start         <= start_nx;
            RES_read_en      <= rd_en_nx;
            RES_read_address <= rd_addr_nx;
            frame_err        <= ferr_nx;
        end
    end

endmodule

// File: tb/tb_coproc_sequencer.sv
// tb_coproc_sequencer: randomized frames with behavioural RAMs and multiplier,
// scored against a frame-level reference model.
module tb_coproc_sequencer;

    localparam int P_WAIT = 0;
    localparam int P_IN   = 1;
    localparam int P_COMP = 2;
    localparam int P_OUT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TLAST;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;
    logic        A_write_en;
    logic [2:0]  A_write_address;
    logic [7:0]  A_write_data_in;
    logic        B_write_en;
    logic [1:0]  B_write_address;
    logic [7:0]  B_write_data_in;
    logic        MM_Start;
    logic        MM_Done;
    logic        RES_read_en;
    logic [0:0]  RES_read_address;
    logic [7:0]  RES_read_data_out;
    logic        frame_err;

    always #5 clk = ~clk;

    coproc_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .S_AXIS_TDATA      (S_AXIS_TDATA),
        .S_AXIS_TVALID     (S_AXIS_TVALID),
        .S_AXIS_TREADY     (S_AXIS_TREADY),
        .S_AXIS_TLAST      (S_AXIS_TLAST),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TREADY     (M_AXIS_TREADY),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .A_write_en        (A_write_en),
        .A_write_address   (A_write_address),
        .A_write_data_in   (A_write_data_in),
        .B_write_en        (B_write_en),
        .B_write_address   (B_write_address),
        .B_write_data_in   (B_write_data_in),
        .MM_Start          (MM_Start),
        .MM_Done           (MM_Done),
        .RES_read_en       (RES_read_en),
        .RES_read_address  (RES_read_address),
        .RES_read_data_out (RES_read_data_out),
        .frame_err         (frame_err)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] src_w [12];
    logic       src_l [12];
    logic [7:0] fw [12];
    logic [7:0] ram_a [8];
    logic [7:0] ram_b [4];
    logic [7:0] ram_res [2];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    int src_i = 12;
    int vmode = 0;
    int gap_ph = 0;
    int mrdy_mode = 0;
    int stall = 0;
    int nb = 0;
    int wr_idx = 0;
    int out_cnt = 0;
    int starts = 0;
    int mm_cnt = -1;
    int tv_wait = -1;
    int real_done = 0;
    int phase = P_WAIT;
    int turn = 0;

    logic        ferr_exp = 1'b0;
    logic        beat_prev = 1'b0;
    logic        startchk = 1'b0;
    logic        frame_done = 1'b0;
    logic        hold_v = 1'b0;
    logic        hold_l = 1'b0;
    logic        inject_done = 1'b0;
    logic [31:0] hold_d = '0;
    logic [7:0]  rd_next = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inspect what the coming edge will do, take the edge,
    // then check registered outputs and drive the next inputs.
    task automatic tick();
        logic beat;
        logic hs;
        if (hold_v) begin
            chk("hold_valid", 64'(M_AXIS_TVALID), 64'(1));
            chk("hold_data", 64'(M_AXIS_TDATA), 64'(hold_d));
            chk("hold_last", 64'(M_AXIS_TLAST), 64'(hold_l));
        end
        hold_v = M_AXIS_TVALID && !M_AXIS_TREADY;
        hold_d = M_AXIS_TDATA;
        hold_l = M_AXIS_TLAST;
        beat = S_AXIS_TVALID && S_AXIS_TREADY;
        hs = M_AXIS_TVALID && M_AXIS_TREADY;

        chk("write_strobe", 64'(A_write_en | B_write_en), 64'(beat_prev));
        if (A_write_en) begin
            chk("a_region", 64'(wr_idx < 8), 64'(1));
            if (wr_idx < 8) begin
                chk("a_addr", 64'(A_write_address), 64'(wr_idx));
                chk("a_data", 64'(A_write_data_in), 64'(fw[wr_idx]));
            end
            ram_a[A_write_address] = A_write_data_in;
            wr_idx++;
        end
        if (B_write_en) begin
            chk("b_region", 64'(wr_idx >= 8 && wr_idx < 12), 64'(1));
            if (wr_idx >= 8 && wr_idx < 12) begin
                chk("b_addr", 64'(B_write_address), 64'(wr_idx - 8));
                chk("b_data", 64'(B_write_data_in), 64'(fw[wr_idx]));
            end
            ram_b[B_write_address] = B_write_data_in;
            wr_idx++;
        end

        if (real_done == 1) begin
            chk("read_after_done", 64'({RES_read_en, RES_read_address}),
                64'(2'b10));
        end
        if (real_done > 0) real_done--;

        if (MM_Start) begin
            starts++;
            mm_cnt = $urandom_range(2, 5);
        end
        if (RES_read_en) begin
            chk("read_phase", 64'(phase == P_OUT), 64'(1));
            chk("read_addr", 64'(RES_read_address), 64'(out_cnt));
            rd_next = ram_res[RES_read_address];
            tv_wait = 2;
        end

        if (beat) begin
            chk("beat_phase", 64'(phase == P_IN), 64'(1));
            if (nb < 12) begin
                fw[nb] = S_AXIS_TDATA[7:0];
                if (S_AXIS_TLAST != (nb == 11)) ferr_exp = 1'b1;
            end
            nb++;
            src_i++;
            if (nb == 12) begin
                for (int i = 0; i < 2; i++) begin
                    int s;
                    s = 0;
                    for (int j = 0; j < 4; j++)
                        s += int'(fw[i*4+j]) * int'(fw[8+j]);
                    exp_q.push_back(8'(s >> 8));
                end
                phase = P_COMP;
                startchk = 1'b1;
            end
        end

        if (hs) begin
            chk("out_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                chk("out_data", 64'(M_AXIS_TDATA), 64'({24'b0, exp_q[0]}));
                chk("out_last", 64'(M_AXIS_TLAST), 64'(out_cnt == 1));
                void'(exp_q.pop_front());
            end
            got_q.push_back(M_AXIS_TDATA[7:0]);
            out_cnt++;
            if (out_cnt == 2) begin
                chk("start_pulses", 64'(starts), 64'(1));
                frame_done = 1'b1;
                phase = P_WAIT;
                turn = 2;
                nb = 0;
                wr_idx = 0;
                out_cnt = 0;
                starts = 0;
            end
        end

        @(posedge clk);
        @(negedge clk);

        RES_read_data_out = rd_next;
        if (turn > 0) begin
            turn--;
            if (turn == 0) phase = P_IN;
        end
        chk("s_tready", 64'(S_AXIS_TREADY), 64'(phase == P_IN));
        chk("frame_err", 64'(frame_err), 64'(ferr_exp));
        chk("mm_start", 64'(MM_Start), 64'(startchk));
        startchk = 1'b0;
        beat_prev = beat;
        if (tv_wait > 0) begin
            tv_wait--;
            if (tv_wait == 1) begin
                chk("tvalid_early", 64'(M_AXIS_TVALID), 64'(0));
            end else begin
                chk("tvalid_rise", 64'(M_AXIS_TVALID), 64'(1));
                tv_wait = -1;
            end
        end

        MM_Done = 1'b0;
        if (mm_cnt > 0) begin
            mm_cnt--;
            if (mm_cnt == 0) begin
                for (int i = 0; i < 2; i++) begin
                    int s;
                    s = 0;
                    for (int j = 0; j < 4; j++)
                        s += int'(ram_a[i*4+j]) * int'(ram_b[j]);
                    ram_res[i] = 8'(s >> 8);
                end
                MM_Done = 1'b1;
                real_done = 2;
                phase = P_OUT;
                mm_cnt = -1;
            end
        end
        if (inject_done) begin
            MM_Done = 1'b1;
            inject_done = 1'b0;
        end

        case (mrdy_mode)
            0: M_AXIS_TREADY = 1'b1;
            1: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            default: begin
                if (M_AXIS_TVALID) begin
                    if (stall > 0) begin
                        M_AXIS_TREADY = 1'b0;
                        stall--;
                    end else begin
                        M_AXIS_TREADY = 1'b1;
                    end
                end else begin
                    stall = 5;
                    M_AXIS_TREADY = 1'b0;
                end
            end
        endcase

        if (src_i < 12) begin
            case (vmode)
                0: S_AXIS_TVALID = 1'b1;
                1: S_AXIS_TVALID = 1'($urandom_range(0, 1));
                default: S_AXIS_TVALID = (gap_ph % 3 == 0);
            endcase
            gap_ph++;
            S_AXIS_TDATA = {24'($urandom()), src_w[src_i]};
            S_AXIS_TLAST = src_l[src_i];
        end else begin
            S_AXIS_TVALID = 1'b0;
            S_AXIS_TLAST = 1'b0;
        end
    endtask

    task automatic do_reset(input int cyc);
        reset = 1'b1;
        for (int c = 0; c < cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_outputs",
                64'({S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
                     A_write_en, A_write_address, A_write_data_in,
                     B_write_en, B_write_address, B_write_data_in,
                     MM_Start, RES_read_en, RES_read_address, frame_err}),
                64'(0));
        end
        reset = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST = 1'b0;
        M_AXIS_TREADY = 1'b0;
        // A stray done pulse right after reset must be ignored.
        MM_Done = 1'b1;
        exp_q.delete();
        phase = P_WAIT;
        turn = 1;
        src_i = 12;
        nb = 0;
        wr_idx = 0;
        out_cnt = 0;
        starts = 0;
        mm_cnt = -1;
        tv_wait = -1;
        real_done = 0;
        ferr_exp = 1'b0;
        beat_prev = 1'b0;
        startchk = 1'b0;
        hold_v = 1'b0;
    endtask

    task automatic load_nominal();
        for (int i = 0; i < 12; i++) begin
            src_w[i] = (i >= 4 && i < 8) ? 8'd32 : 8'd16;
            src_l[i] = (i == 11);
        end
        src_i = 0;
        gap_ph = 0;
    endtask

    task automatic load_random();
        for (int i = 0; i < 12; i++) begin
            src_w[i] = 8'($urandom());
            src_l[i] = (i == 11);
        end
        src_i = 0;
        gap_ph = 0;
    endtask

    task automatic run_frame(input string tag);
        frame_done = 1'b0;
        got_q.delete();
        for (int c = 0; c < 600 && !frame_done; c++) tick();
        chk({tag, "_done"}, 64'(frame_done), 64'(1));
    endtask

    initial begin
        reset = 1'b1;
        S_AXIS_TDATA = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST = 1'b0;
        M_AXIS_TREADY = 1'b0;
        MM_Done = 1'b0;
        RES_read_data_out = '0;
        do_reset(3);

        vmode = 0;
        mrdy_mode = 0;
        load_nominal();
        run_frame("nominal");
        chk("nominal_res0", 64'(got_q[0]), 64'(4));
        chk("nominal_res1", 64'(got_q[1]), 64'(8));

        mrdy_mode = 2;
        load_random();
        run_frame("backpressure");

        mrdy_mode = 0;
        vmode = 2;
        inject_done = 1'b1;
        load_random();
        run_frame("gaps");

        vmode = 1;
        mrdy_mode = 1;
        for (int k = 0; k < 3; k++) begin
            load_random();
            run_frame("random");
        end

        vmode = 0;
        mrdy_mode = 0;
        load_random();
        src_l[5] = 1'b1;
        src_l[11] = 1'b0;
        run_frame("framing");
        chk("frame_err_set", 64'(frame_err), 64'(1));
        load_nominal();
        run_frame("after_err");
        chk("frame_err_sticky", 64'(frame_err), 64'(1));

        load_nominal();
        for (int c = 0; c < 200 && nb < 7; c++) tick();
        chk("mid_beats", 64'(nb), 64'(7));
        do_reset(2);
        load_nominal();
        run_frame("post_reset");
        chk("post_reset_res0", 64'(got_q[0]), 64'(4));
        chk("post_reset_res1", 64'(got_q[1]), 64'(8));

        vmode = 1;
        load_random();
        run_frame("b2b_1");
        load_random();
        run_frame("b2b_2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
